// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline definitions: ALUOp encodings, control bundle, bubble constant.
// Pure declarations; no timing or backpressure involved.
// Imported by every stage that carries decode control signals.
package rv32_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REG_W    = 5;
   localparam int FUNCT_W  = 4;

   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_RTYPE  = 2'b10,
      ALU_OP_ITYPE  = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic    branch;
      logic    mem_read;
      logic    mem_to_reg;
      logic    mem_write;
      logic    alu_src;
      logic    reg_write;
      alu_op_e alu_op;
   } ctrl_t;

   // A bubble carries no side effects: nothing written, nothing read from memory.
   localparam ctrl_t CTRL_NOP = '{
      branch:     1'b0,
      mem_read:   1'b0,
      mem_to_reg: 1'b0,
      mem_write:  1'b0,
      alu_src:    1'b0,
      reg_write:  1'b0,
      alu_op:     ALU_OP_ADD
   };

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detector: EX load whose rd feeds either ID source register.
// Latency: combinational.
// Backpressure: none; the stage converts load_use into a stall.
module hazard_detect_unit
   import rv32_pkg::*;
(
   input  logic             ex_valid,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   output logic             load_use
);

   logic rd_live;
   logic src_match;

   // Both sources are compared whatever the format; an unused rs2 may stall spuriously.
   assign rd_live   = ex_valid & ex_mem_read & (ex_rd != '0);
   assign src_match = (ex_rd == id_rs1) | (ex_rd == id_rs2);
   assign load_use  = rd_live & id_valid & src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and saturating perf counters.
// Latency: 1 cycle from id_* to ex_*.
// Backpressure: hold freezes the stage; load_use or hold deasserts the PC/IF-ID enables unless flushing.
module id_ex_stage
   import rv32_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_branch,
   input  logic               id_mem_read,
   input  logic               id_mem_to_reg,
   input  logic               id_mem_write,
   input  logic               id_alu_src,
   input  logic               id_reg_write,
   input  logic [1:0]         id_alu_op,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [REG_W-1:0]   id_rs1,
   input  logic [REG_W-1:0]   id_rs2,
   input  logic [REG_W-1:0]   id_rd,
   input  logic [FUNCT_W-1:0] id_funct,
   input  logic               id_valid,
   input  logic               flush,
   input  logic               hold,
   output logic               ex_branch,
   output logic               ex_mem_read,
   output logic               ex_mem_to_reg,
   output logic               ex_mem_write,
   output logic               ex_alu_src,
   output logic               ex_reg_write,
   output logic [1:0]         ex_alu_op,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_rs1_data,
   output logic [XLEN-1:0]    ex_rs2_data,
   output logic [XLEN-1:0]    ex_imm,
   output logic [REG_W-1:0]   ex_rs1,
   output logic [REG_W-1:0]   ex_rs2,
   output logic [REG_W-1:0]   ex_rd,
   output logic [FUNCT_W-1:0] ex_funct,
   output logic               ex_valid,
   output logic               pc_write_en,
   output logic               if_id_write_en,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  load_use;
   logic  advance_en;

   assign id_ctrl = '{
      branch:     id_branch,
      mem_read:   id_mem_read,
      mem_to_reg: id_mem_to_reg,
      mem_write:  id_mem_write,
      alu_src:    id_alu_src,
      reg_write:  id_reg_write,
      alu_op:     alu_op_e'(id_alu_op)
   };

   hazard_detect_unit u_hdu (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl.mem_read),
      .ex_rd       (ex_rd),
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .load_use    (load_use)
   );

   // A flush must always let fetch redirect, even over a stall or hold.
   assign advance_en     = rst | flush | ~(load_use | hold);
   assign pc_write_en    = advance_en;
   assign if_id_write_en = advance_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_ctrl     <= CTRL_NOP;
         ex_valid    <= 1'b0;
         ex_rd       <= '0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_funct    <= '0;
      end else if (!hold || flush) begin
         // Datapath fields load on every bubble too, so their content stays deterministic.
         ex_pc       <= id_pc;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_funct    <= id_funct;
         if (flush || load_use) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
            ex_rd    <= '0;
         end else begin
            ex_ctrl  <= id_ctrl;
            ex_valid <= id_valid;
            ex_rd    <= id_rd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (flush) begin
         if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (!hold && load_use) begin
         if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign ex_branch     = ex_ctrl.branch;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a priority-rule reference model.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        valid;
      logic        branch;
      logic        mem_read;
      logic        mem_to_reg;
      logic        mem_write;
      logic        alu_src;
      logic        reg_write;
      logic [1:0]  alu_op;
      logic [31:0] pc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  funct;
   } stage_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic hold = 1'b0;
   stage_t idv = '0;
   stage_t obs;
   logic pc_write_en, if_id_write_en;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   stage_t exp_ex = '0;
   int exp_sc = 0;
   int exp_fc = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_branch(idv.branch), .id_mem_read(idv.mem_read), .id_mem_to_reg(idv.mem_to_reg),
      .id_mem_write(idv.mem_write), .id_alu_src(idv.alu_src), .id_reg_write(idv.reg_write),
      .id_alu_op(idv.alu_op), .id_pc(idv.pc), .id_rs1_data(idv.d1), .id_rs2_data(idv.d2),
      .id_imm(idv.imm), .id_rs1(idv.rs1), .id_rs2(idv.rs2), .id_rd(idv.rd),
      .id_funct(idv.funct), .id_valid(idv.valid), .flush(flush), .hold(hold),
      .ex_branch(obs.branch), .ex_mem_read(obs.mem_read), .ex_mem_to_reg(obs.mem_to_reg),
      .ex_mem_write(obs.mem_write), .ex_alu_src(obs.alu_src), .ex_reg_write(obs.reg_write),
      .ex_alu_op(obs.alu_op), .ex_pc(obs.pc), .ex_rs1_data(obs.d1), .ex_rs2_data(obs.d2),
      .ex_imm(obs.imm), .ex_rs1(obs.rs1), .ex_rs2(obs.rs2), .ex_rd(obs.rd),
      .ex_funct(obs.funct), .ex_valid(obs.valid),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string tag, input logic [159:0] o, input logic [159:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic stage_t bubble_of(input stage_t s);
      stage_t b;
      b = '0;
      b.pc = s.pc; b.d1 = s.d1; b.d2 = s.d2; b.imm = s.imm;
      b.rs1 = s.rs1; b.rs2 = s.rs2; b.funct = s.funct;
      return b;
   endfunction

   // The instruction in EX is a load whose destination is read by the one in ID.
   function automatic bit model_load_use();
      return exp_ex.valid && exp_ex.mem_read && exp_ex.rd != 0 && idv.valid &&
             (exp_ex.rd == idv.rs1 || exp_ex.rd == idv.rs2);
   endfunction

   function automatic stage_t rand_instr(input int reg_span);
      stage_t s;
      s = '0;
      {s.branch, s.mem_read, s.mem_to_reg, s.mem_write, s.alu_src, s.reg_write} = 6'($urandom);
      s.alu_op = 2'($urandom);
      s.valid = ($urandom_range(0, 9) != 0);
      s.pc = $urandom; s.d1 = $urandom; s.d2 = $urandom; s.imm = $urandom;
      s.rs1 = 5'($urandom_range(0, reg_span));
      s.rs2 = 5'($urandom_range(0, reg_span));
      s.rd  = 5'($urandom_range(0, reg_span));
      s.funct = 4'($urandom);
      return s;
   endfunction

   // One clock: check enables mid-cycle, advance the model on the edge, check registered state.
   task automatic step(input string tag);
      bit lu, en;
      @(negedge clk);
      lu = model_load_use();
      en = flush || !(lu || hold);
      check({tag, ".pc_we"}, 160'(pc_write_en), 160'(en));
      check({tag, ".ifid_we"}, 160'(if_id_write_en), 160'(en));
      @(posedge clk);
      if (flush) begin
         exp_ex = bubble_of(idv);
         if (exp_fc < CMAX) exp_fc++;
      end else if (hold) begin
         exp_ex = exp_ex;
      end else if (lu) begin
         exp_ex = bubble_of(idv);
         if (exp_sc < CMAX) exp_sc++;
      end else begin
         exp_ex = idv;
      end
      #1;
      check({tag, ".ex"}, 160'(obs), 160'(exp_ex));
      check({tag, ".stall_cnt"}, 160'(stall_cnt), 160'(exp_sc));
      check({tag, ".flush_cnt"}, 160'(flush_cnt), 160'(exp_fc));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      exp_ex = '0; exp_sc = 0; exp_fc = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      stage_t lw, add, snap;

      // Reset state
      #2;
      check("reset.ex", 160'(obs), 160'(0));
      check("reset.cnts", 160'({stall_cnt, flush_cnt}), 160'(0));
      check("reset.en", 160'({pc_write_en, if_id_write_en}), 160'(2'b11));
      @(negedge clk);
      rst = 1'b0;

      // Pass-through
      idv = '0;
      idv.valid = 1; idv.pc = 32'h100; idv.d1 = 32'hDEADBEEF; idv.reg_write = 1; idv.rd = 5;
      idv.rs1 = 7; idv.rs2 = 8;
      step("pass");
      check("pass.pc", 160'(obs.pc), 160'(32'h100));
      check("pass.d1", 160'(obs.d1), 160'(32'hDEADBEEF));

      // Load-use: lw x5 in EX, add reading x5 in ID
      lw = '0; lw.valid = 1; lw.mem_read = 1; lw.mem_to_reg = 1; lw.reg_write = 1;
      lw.alu_src = 1; lw.rd = 5; lw.rs1 = 2; lw.pc = 32'h104;
      add = '0; add.valid = 1; add.reg_write = 1; add.alu_op = 2'b10; add.rs1 = 5;
      add.rs2 = 6; add.rd = 7; add.pc = 32'h108;
      idv = lw;
      step("lu.lw");
      idv = add;
      step("lu.stall");
      check("lu.bubble_valid", 160'(obs.valid), 160'(0));
      check("lu.stall_cnt1", 160'(stall_cnt), 160'(1));
      step("lu.issue");
      check("lu.add_issued", 160'({obs.valid, obs.rd}), 160'({1'b1, 5'd7}));

      // Load to x0 never stalls
      lw.rd = 0;
      idv = lw;
      step("x0.lw");
      add.rs1 = 0; add.rs2 = 0;
      idv = add;
      step("x0.add");
      check("x0.no_stall", 160'(stall_cnt), 160'(1));

      // Flush beats hold and load_use together
      do_reset();
      lw.rd = 5;
      idv = lw;
      step("fl.lw");
      add.rs1 = 5;
      idv = add; flush = 1; hold = 1;
      step("fl.flush");
      check("fl.cnts", 160'({stall_cnt, flush_cnt}), 160'({4'd0, 4'd1}));
      flush = 0; hold = 0;

      // Hold freezes for three cycles under changing inputs
      idv = rand_instr(31);
      step("hold.load");
      snap = obs;
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         idv = rand_instr(31);
         step("hold.cyc");
      end
      check("hold.frozen", 160'(obs), 160'(snap));
      hold = 0;

      // Randomized traffic with dense register aliasing
      for (int i = 0; i < 400; i++) begin
         idv = rand_instr(3);
         flush = ($urandom_range(0, 9) == 0);
         hold  = ($urandom_range(0, 6) == 0);
         step("rand");
      end
      flush = 0; hold = 0;

      // Stall counter saturation
      do_reset();
      lw.rd = 5;
      for (int i = 0; i < CMAX + 5; i++) begin
         idv = lw;
         step("sat.lw");
         idv = add;
         step("sat.stall");
      end
      check("sat.stall_max", 160'(stall_cnt), 160'(CMAX));

      // Asynchronous reset mid-stall with hold asserted
      idv = lw;
      step("ar.lw");
      idv = add; hold = 1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("ar.ex", 160'(obs), 160'(0));
      check("ar.cnts", 160'({stall_cnt, flush_cnt}), 160'(0));
      check("ar.en", 160'({pc_write_en, if_id_write_en}), 160'(2'b11));
      exp_ex = '0; exp_sc = 0; exp_fc = 0;
      @(negedge clk);
      rst = 1'b0; hold = 0;
      idv = rand_instr(31);
      step("ar.after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
